// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle add/sub, shift-add multiply, restoring divide.
// Define SEQ_ALU_SAT_EN for unsigned saturation of add/sub/mul results.
module seq_alu #(
   parameter int WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [1:0]       Opcode,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Result,
   output logic [WIDTH-1:0] ResultHi,
   output logic             Cout,
   output logic             OF,
   output logic             DivZero
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic [2:0] {IDLE, ADDSUB, MUL, DIV, DONE} state_t;

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [1:0]       op_code;
   logic             op_cin;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic             accept;

   logic             is_sub;
   logic [WIDTH-1:0] b_eff;
   logic             c_in;
   logic [WIDTH:0]   sum_ext;
   logic             carry_msb;
   logic             as_cout;
   logic             as_of;
   logic [WIDTH-1:0] as_result;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_hi_next;
   logic [WIDTH-1:0] mul_lo_next;
   logic [WIDTH-1:0] mul_result;

   logic [WIDTH:0]   div_shifted;
   logic             div_fits;
   logic [WIDTH-1:0] div_hi_next;
   logic [WIDTH-1:0] div_lo_next;

   assign accept = Start && ((state == IDLE) || (state == DONE));

   // Subtraction reuses the adder as A + ~B + 1, so Cout means "no borrow".
   assign is_sub    = (op_code == OP_SUB);
   assign b_eff     = is_sub ? ~op_b : op_b;
   assign c_in      = is_sub ? 1'b1 : op_cin;
   assign sum_ext   = {1'b0, op_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_in};
   assign carry_msb = op_a[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum_ext[WIDTH-1];
   assign as_cout   = sum_ext[WIDTH];
   assign as_of     = carry_msb ^ as_cout;

`ifdef SEQ_ALU_SAT_EN
   always_comb begin
      as_result = sum_ext[WIDTH-1:0];
      if (!is_sub && as_cout)
         as_result = '1;
      else if (is_sub && !as_cout)
         as_result = '0;
   end
`else
   assign as_result = sum_ext[WIDTH-1:0];
`endif

   // Multiplier sits in acc_lo and shifts out LSB-first while the product fills from the top.
   assign mul_sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_a} : {(WIDTH+1){1'b0}});
   assign mul_hi_next = mul_sum[WIDTH:1];
   assign mul_lo_next = {mul_sum[0], acc_lo[WIDTH-1:1]};

`ifdef SEQ_ALU_SAT_EN
   assign mul_result = (mul_hi_next != '0) ? '1 : mul_lo_next;
`else
   assign mul_result = mul_lo_next;
`endif

   // Dividend shifts out of acc_lo into the remainder; quotient bits shift in behind it.
   assign div_shifted = {acc_hi, acc_lo[WIDTH-1]};
   assign div_fits    = (div_shifted >= {1'b0, op_b});
   assign div_hi_next = div_fits ? (div_shifted[WIDTH-1:0] - op_b) : div_shifted[WIDTH-1:0];
   assign div_lo_next = {acc_lo[WIDTH-2:0], div_fits};

   // State register
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state logic; divide by zero takes the single-cycle path
   always_comb begin
      next_state = state;
      case (state)
         IDLE, DONE: begin
            if (Start) begin
               case (Opcode)
                  OP_MUL:  next_state = MUL;
                  OP_DIV:  next_state = (B == '0) ? ADDSUB : DIV;
                  default: next_state = ADDSUB;
               endcase
            end else begin
               next_state = IDLE;
            end
         end
         ADDSUB:  next_state = DONE;
         MUL:     next_state = (count == LAST) ? DONE : MUL;
         DIV:     next_state = (count == LAST) ? DONE : DIV;
         default: next_state = IDLE;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      Busy = 1'b0;
      Done = 1'b0;
      case (state)
         ADDSUB, MUL, DIV: Busy = 1'b1;
         DONE:             Done = 1'b1;
         default:          ;
      endcase
   end

   // Operand capture, iterative datapath and registered results
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         op_a     <= '0;
         op_b     <= '0;
         op_code  <= '0;
         op_cin   <= 1'b0;
         count    <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         Result   <= '0;
         ResultHi <= '0;
         Cout     <= 1'b0;
         OF       <= 1'b0;
         DivZero  <= 1'b0;
      end else if (accept) begin
         op_a     <= A;
         op_b     <= B;
         op_code  <= Opcode;
         op_cin   <= Cin;
         count    <= '0;
         acc_hi   <= '0;
         acc_lo   <= (Opcode == OP_DIV) ? A : B;
         Result   <= '0;
         ResultHi <= '0;
         Cout     <= 1'b0;
         OF       <= 1'b0;
         DivZero  <= 1'b0;
      end else begin
         case (state)
            ADDSUB: begin
               if (op_code == OP_DIV) begin
                  Result   <= '1;
                  ResultHi <= op_a;
                  DivZero  <= 1'b1;
               end else begin
                  Result <= as_result;
                  Cout   <= as_cout;
                  OF     <= as_of;
               end
            end
            MUL: begin
               acc_hi <= mul_hi_next;
               acc_lo <= mul_lo_next;
               count  <= (count == LAST) ? '0 : count + CW'(1);
               if (count == LAST) begin
                  Result   <= mul_result;
                  ResultHi <= mul_hi_next;
               end
            end
            DIV: begin
               acc_hi <= div_hi_next;
               acc_lo <= div_lo_next;
               count  <= (count == LAST) ? '0 : count + CW'(1);
               if (count == LAST) begin
                  Result   <= div_lo_next;
                  ResultHi <= div_hi_next;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: expected results are queued at issue and popped at Done.
module tb_seq_alu;

   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] res;
      logic [W-1:0] hi;
      logic         cout;
      logic         of;
      logic         dz;
      logic [7:0]   lat;
   } exp_t;

   logic         Clk = 1'b0;
   logic         Reset = 1'b1;
   logic         Start = 1'b0;
   logic [1:0]   Opcode = 2'b00;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         Cin = 1'b0;
   logic         Busy;
   logic         Done;
   logic [W-1:0] Result;
   logic [W-1:0] ResultHi;
   logic         Cout;
   logic         OF;
   logic         DivZero;

   int   checks = 0;
   int   failures = 0;
   exp_t sb[$];

   seq_alu #(.WIDTH(W)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Opcode(Opcode), .A(A), .B(B), .Cin(Cin),
      .Busy(Busy), .Done(Done), .Result(Result), .ResultHi(ResultHi),
      .Cout(Cout), .OF(OF), .DivZero(DivZero)
   );

   always #5 Clk = ~Clk;

   // Reference model built from plain arithmetic operators
   function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin);
      exp_t           e;
      logic [W:0]     s;
      logic [2*W-1:0] p;
      e = '0;
      case (op)
         2'b00: begin
            s = a + b + cin;
            e.res = s[W-1:0];
            e.cout = s[W];
            e.of = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
            e.lat = 8'd1;
`ifdef SEQ_ALU_SAT_EN
            if (e.cout) e.res = '1;
`endif
         end
         2'b01: begin
            s = {1'b0, a} - {1'b0, b};
            e.res = s[W-1:0];
            e.cout = (a >= b);
            e.of = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
            e.lat = 8'd1;
`ifdef SEQ_ALU_SAT_EN
            if (!e.cout) e.res = '0;
`endif
         end
         2'b10: begin
            p = a * b;
            e.res = p[W-1:0];
            e.hi = p[2*W-1:W];
            e.lat = 8'(W);
`ifdef SEQ_ALU_SAT_EN
            if (e.hi != '0) e.res = '1;
`endif
         end
         default: begin
            if (b == '0) begin
               e.res = '1;
               e.hi = a;
               e.dz = 1'b1;
               e.lat = 8'd1;
            end else begin
               e.res = a / b;
               e.hi = a % b;
               e.lat = 8'(W);
            end
         end
      endcase
      return e;
   endfunction

   task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin);
      @(negedge Clk);
      Start = 1'b1;
      Opcode = op;
      A = a;
      B = b;
      Cin = cin;
      sb.push_back(model(op, a, b, cin));
      @(posedge Clk);
      #1;
      Start = 1'b0;
   endtask

   // Counts edges until Done, returning -1 if it never arrives
   task automatic wait_done(output int lat);
      bit seen;
      seen = 1'b0;
      lat = -1;
      for (int i = 1; i <= 40 && !seen; i++) begin
         @(posedge Clk);
         #1;
         if (Done) begin
            seen = 1'b1;
            lat = i;
         end
      end
   endtask

   task automatic test_reset;
      #12;
      checks++;
      if ({Busy, Done, Result, ResultHi, Cout, OF, DivZero} !== '0) begin
         failures++;
         $display("[TB] FAIL reset_outputs: got %h expected 0",
                  {Busy, Done, Result, ResultHi, Cout, OF, DivZero});
      end
      @(negedge Clk);
      Reset = 1'b0;
   endtask

   task automatic test_arith;
      int   ops[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
      int   va[9]  = '{200, 100, 5, 7, 200, 255, 100, 9, 127};
      int   vb[9]  = '{100, 100, 7, 5, 3, 255, 7, 0, 0};
      int   vc[9]  = '{0, 1, 0, 1, 0, 0, 0, 0, 1};
      int   lat;
      exp_t e;
      for (int i = 0; i < 9; i++) begin
         applyStimulus(2'(ops[i]), W'(va[i]), W'(vb[i]), 1'(vc[i]));
         checks++;
         if (Busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL busy_after_start[%0d]: got %b expected 1", i, Busy);
         end
         wait_done(lat);
         e = sb.pop_front();
         checks++;
         if (lat != int'(e.lat)) begin
            failures++;
            $display("[TB] FAIL latency[%0d]: got %0d expected %0d", i, lat, e.lat);
         end
         checks++;
         if ({Result, ResultHi, Cout, OF, DivZero} !== {e.res, e.hi, e.cout, e.of, e.dz}) begin
            failures++;
            $display("[TB] FAIL result[%0d]: got res=%h hi=%h cout=%b of=%b dz=%b expected res=%h hi=%h cout=%b of=%b dz=%b",
                     i, Result, ResultHi, Cout, OF, DivZero, e.res, e.hi, e.cout, e.of, e.dz);
         end
         @(posedge Clk);
         #1;
         checks++;
         if ({Done, Busy, Result, ResultHi, Cout, OF, DivZero} !==
             {2'b00, e.res, e.hi, e.cout, e.of, e.dz}) begin
            failures++;
            $display("[TB] FAIL hold_after_done[%0d]: got done=%b busy=%b res=%h hi=%h expected done=0 busy=0 res=%h hi=%h",
                     i, Done, Busy, Result, ResultHi, e.res, e.hi);
         end
      end
   endtask

   task automatic test_busy_ignore;
      int   lat;
      exp_t e;
      applyStimulus(2'b10, 8'd200, 8'd3, 1'b0);
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      Start = 1'b1;
      Opcode = 2'b00;
      A = 8'd1;
      B = 8'd1;
      @(posedge Clk);
      #1;
      Start = 1'b0;
      checks++;
      if ({Busy, Done} !== 2'b10) begin
         failures++;
         $display("[TB] FAIL ignore_busy_state: got busy=%b done=%b expected busy=1 done=0", Busy, Done);
      end
      wait_done(lat);
      e = sb.pop_front();
      checks++;
      if ((lat < 0) || (lat + 3 != int'(e.lat))) begin
         failures++;
         $display("[TB] FAIL ignore_latency: got %0d expected %0d", lat + 3, e.lat);
      end
      checks++;
      if ({Result, ResultHi} !== {e.res, e.hi}) begin
         failures++;
         $display("[TB] FAIL ignore_result: got %h_%h expected %h_%h", ResultHi, Result, e.hi, e.res);
      end
   endtask

   task automatic test_back_to_back;
      int   lat;
      exp_t e;
      applyStimulus(2'b00, 8'd10, 8'd20, 1'b0);
      wait_done(lat);
      e = sb.pop_front();
      checks++;
      if ((lat != 1) || (Result !== e.res)) begin
         failures++;
         $display("[TB] FAIL b2b_first: got lat=%0d res=%h expected lat=1 res=%h", lat, Result, e.res);
      end
      applyStimulus(2'b01, 8'd50, 8'd20, 1'b0);
      checks++;
      if ({Done, Busy, Result} !== {2'b01, 8'd0}) begin
         failures++;
         $display("[TB] FAIL b2b_accept: got done=%b busy=%b res=%h expected done=0 busy=1 res=00",
                  Done, Busy, Result);
      end
      wait_done(lat);
      e = sb.pop_front();
      checks++;
      if ((lat != 1) || ({Result, Cout, OF} !== {e.res, e.cout, e.of})) begin
         failures++;
         $display("[TB] FAIL b2b_second: got lat=%0d res=%h cout=%b of=%b expected lat=1 res=%h cout=%b of=%b",
                  lat, Result, Cout, OF, e.res, e.cout, e.of);
      end
   endtask

   task automatic test_reset_mid_op;
      int   lat;
      bit   saw_done;
      exp_t e;
      applyStimulus(2'b11, 8'd100, 8'd7, 1'b0);
      repeat (3) @(posedge Clk);
      #2;
      Reset = 1'b1;
      #1;
      e = sb.pop_front();
      checks++;
      if ({Busy, Done, Result, ResultHi, Cout, OF, DivZero} !== '0) begin
         failures++;
         $display("[TB] FAIL async_reset: got %h expected 0", {Busy, Done, Result, ResultHi, Cout, OF, DivZero});
      end
      saw_done = 1'b0;
      repeat (10) begin
         @(posedge Clk);
         #1;
         if (Done || Busy) saw_done = 1'b1;
      end
      checks++;
      if (saw_done) begin
         failures++;
         $display("[TB] FAIL reset_no_done: got activity=1 expected 0");
      end
      @(negedge Clk);
      Reset = 1'b0;
      applyStimulus(2'b00, 8'd1, 8'd1, 1'b0);
      wait_done(lat);
      e = sb.pop_front();
      checks++;
      if ((lat != 1) || (Result !== e.res)) begin
         failures++;
         $display("[TB] FAIL post_reset_add: got lat=%0d res=%h expected lat=1 res=%h", lat, Result, e.res);
      end
   endtask

   initial begin
      $display("[TB] seq_alu bench start");
      test_reset();
      test_arith();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid_op();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
